fifo_drain_serializer: RTL and testbench
========================================

Name: fifo_drain_serializer

Overview:
- Read-side companion of the buffering FIFO: drains the FIFO and serializes each DATA_WIDTH word into OUT_WIDTH slices on a valid/ready stream.
- Owns the FIFO's rd strobe and absorbs the FIFO's one-cycle registered read latency with a 2-entry word buffer.
- Sits between the FIFO and narrower downstream consumers (link/serdes framers).

Parameters:
- DATA_WIDTH, 128: FIFO word width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32: output slice width. R = DATA_WIDTH/OUT_WIDTH; R=1 is legal (pass-through).

Ports:
- clk  in  1  clock.
- arst  in  1  reset, asynchronous, active-high.
- srst  in  1  synchronous reset, active-high; shared with the FIFO.
- fifo_mty  in  1  FIFO empty flag.
- fifo_almost_mty  in  1  FIFO almost-empty flag; monitoring only, no functional use.
- fifo_q  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd.
- fifo_rd  out  1  FIFO read strobe.
- out_valid  out  1  slice valid.
- out_ready  in  1  downstream ready.
- out_data  out  OUT_WIDTH  current slice.
- out_last  out  1  marks the final slice (index R-1) of a word.
- busy  out  1  high when any word is buffered or a read is in flight.

Behaviour:
- Reset (arst async; srst sync, same values):
  - cnt (buffered words, 0..2) = 0; inflight = 0; idx = 0; rd/wr pointers = 0.
  - fifo_rd = 0, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
- srst discards any in-flight capture; the FIFO is reset in the same cycle.
- fifo_rd is combinational from registered state:
  - pop = out_valid & out_ready & out_last.
  - fifo_rd = ~fifo_mty & ~srst & (cnt + inflight - pop < 2).
  - fifo_rd is never asserted while fifo_mty = 1.
- inflight <= fifo_rd each cycle. When inflight = 1, fifo_q is written into buffer[wr_ptr] and wr_ptr toggles.
- cnt next = cnt + inflight - pop. Overflow is impossible by the credit rule; the bench asserts cnt <= 2.
- out_valid = (cnt != 0).
- out_data = buffer[rd_ptr][idx*OUT_WIDTH +: OUT_WIDTH]. Slices go out LSB-first.
- out_last = out_valid & (idx == R-1).
- On out_valid & out_ready:
  - idx == R-1: idx -> 0, rd_ptr toggles.
  - otherwise: idx increments.
- out_data is held stable while out_valid & ~out_ready. No slice is dropped or repeated.
- Latency: fifo_rd in cycle N -> word captured at end of N+1 -> out_valid in cycle N+2.
- Throughput: with out_ready held high, one slice per cycle sustained for any R, including R=1 with continuous FIFO data.
- Simultaneous capture and pop in the same cycle: cnt unchanged, both pointers advance.
- Pointer wrap 1 -> 0 is natural (1-bit pointers).
- fifo_mty rising while inflight = 1: the in-flight word is still captured.
- busy = (cnt != 0) | inflight.

Test Plan:
- R=4: write one word 0x44443333_22221111_DDDDCCCC_BBBBAAAA, out_ready=1 -> fifo_rd pulses once; 2 cycles later out_data = 0xBBBBAAAA, 0xDDDDCCCC, 0x22221111, 0x44443333 on consecutive cycles; out_last only on the 4th; busy drops the next cycle.
- R=4, 3 words queued, out_ready toggled 1,0,0,1 repeating -> out_data stable during stalls; exactly 12 slices in order; fifo_rd count = 3; cnt never > 2.
- R=1, 8 words queued, out_ready=1 -> fifo_rd high 8 consecutive cycles; out_valid high 8 consecutive cycles starting 2 cycles after the first rd; data matches write order.
- FIFO empty, out_ready=1 for 20 cycles -> fifo_rd = 0 and out_valid = 0 throughout; then 1 word written -> exactly one rd.
- R=4, srst asserted after the 2nd slice of a word with a second word in flight -> next cycle out_valid=0, idx=0, cnt=0, busy=0; a fresh word afterwards streams correctly from slice 0.
- arst asserted mid-stream, asynchronous to clk -> all outputs 0 immediately, without waiting for a clock edge; normal operation resumes after release.

Source files
------------

// File: rtl/fifo_drain_serializer.sv
// Drains a registered-read FIFO into a 2-entry word buffer and serializes each
// DATA_WIDTH word LSB-first as OUT_WIDTH slices on a valid/ready stream.
module fifo_drain_serializer #(
  parameter int DATA_WIDTH = 128,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  srst,
  input  logic                  fifo_mty,
  input  logic                  fifo_almost_mty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int R  = DATA_WIDTH / OUT_WIDTH;
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(R - 1);

  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  accept, pop;
  logic [2:0]            credit;
  logic                  unused_almost_mty;

  assign unused_almost_mty = fifo_almost_mty;

  always_comb begin
    out_valid = (cnt_q != 2'd0);
    out_last  = out_valid & (idx_q == IDX_LAST);
    out_data  = buf_q[rd_ptr_q][int'(idx_q) * OUT_WIDTH +: OUT_WIDTH];
    accept    = out_valid & out_ready;
    pop       = accept & out_last;
    // Occupancy after this cycle, counting the word already in flight.
    credit    = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    // arst gates the strobe so it drops immediately, like the registered outputs.
    fifo_rd   = ~arst & ~srst & ~fifo_mty & (credit < 3'd2);
    busy      = out_valid | inflight_q;
    cnt_d     = credit[1:0];
    idx_d     = idx_q;
    rd_ptr_d  = rd_ptr_q;
    if (accept) begin
      if (idx_q == IDX_LAST) begin
        idx_d    = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) buf_q[i] <= '0;
    end else if (srst) begin
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= fifo_rd;
      idx_q      <= idx_d;
      rd_ptr_q   <= rd_ptr_d;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= fifo_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Directed bench: R=4 and R=1 instances, each fed by a registered-read FIFO model.
module tb_fifo_drain_serializer;

  logic clk = 1'b0;
  logic arst, srst;
  always #5 clk = ~clk;

  // R=4 instance
  logic         f4_mty, f4_amty, rd4, v4, rdy4, l4, b4;
  logic [127:0] f4_q;
  logic [31:0]  d4;
  // R=1 instance
  logic         f1_mty, f1_amty, rd1, v1, rdy1, l1, b1;
  logic [31:0]  f1_q, d1;

  fifo_drain_serializer #(.DATA_WIDTH(128), .OUT_WIDTH(32)) dut4 (
    .clk(clk), .arst(arst), .srst(srst), .fifo_mty(f4_mty), .fifo_almost_mty(f4_amty),
    .fifo_q(f4_q), .fifo_rd(rd4), .out_valid(v4), .out_ready(rdy4), .out_data(d4),
    .out_last(l4), .busy(b4));

  fifo_drain_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(32)) dut1 (
    .clk(clk), .arst(arst), .srst(srst), .fifo_mty(f1_mty), .fifo_almost_mty(f1_amty),
    .fifo_q(f1_q), .fifo_rd(rd1), .out_valid(v1), .out_ready(rdy1), .out_data(d1),
    .out_last(l1), .busy(b1));

  logic [127:0] q4[$];
  logic [31:0]  q1[$];
  logic [31:0]  got_d[$];
  logic         got_l[$];
  logic [31:0]  got1[$];
  int           rd_cnt4 = 0;
  int           cnt_max = 0;
  int           tests = 0;
  int           fails = 0;

  // FIFO models: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (srst) begin
      q4.delete(); f4_mty <= 1'b1;
      q1.delete(); f1_mty <= 1'b1;
    end else begin
      if (rd4 && q4.size() > 0) begin f4_q <= q4.pop_front(); f4_mty <= (q4.size() == 0); end
      if (rd1 && q1.size() > 0) begin f1_q <= q1.pop_front(); f1_mty <= (q1.size() == 0); end
    end
  end

  always @(posedge clk) begin
    if (rd4) rd_cnt4++;
    if (v4 && rdy4) begin got_d.push_back(d4); got_l.push_back(l4); end
    if (v1 && rdy1) got1.push_back(d1);
    if (int'(dut4.cnt_q) > cnt_max) cnt_max = int'(dut4.cnt_q);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push4(input logic [127:0] w);
    q4.push_back(w); f4_mty = 1'b0;
  endtask

  task automatic push1(input logic [31:0] w);
    q1.push_back(w); f1_mty = 1'b0;
  endtask

  task automatic wait_got(input int n);
    for (int k = 0; k < 40 && got_d.size() < n; k++) @(negedge clk);
  endtask

  task automatic clear_got();
    got_d.delete(); got_l.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  e1 [4];
    logic [127:0] w, wc;
    logic [31:0]  pd;
    logic         stall_prev, seen;
    logic [13:0]  rdh, vh;
    logic [3:0]   pat;
    int           rd0;

    arst = 1'b1; srst = 1'b0; rdy4 = 1'b0; rdy1 = 1'b0;
    f4_mty = 1'b1; f1_mty = 1'b1; f4_amty = 1'b1; f1_amty = 1'b1;
    f4_q = '0; f1_q = '0;
    #2;
    chk("rst_valid", v4, 0); chk("rst_data", d4, 0); chk("rst_last", l4, 0);
    chk("rst_busy", b4, 0);  chk("rst_rd", rd4, 0);  chk("rst_cnt", dut4.cnt_q, 0);
    @(negedge clk); arst = 1'b0;
    @(negedge clk);

    // Single word, R=4
    e1[0] = 32'hBBBBAAAA; e1[1] = 32'hDDDDCCCC; e1[2] = 32'h22221111; e1[3] = 32'h44443333;
    rd0 = rd_cnt4; rdy4 = 1'b1;
    push4(128'h44443333_22221111_DDDDCCCC_BBBBAAAA);
    #1 chk("t1_rd", rd4, 1);
    @(negedge clk); #1;
    chk("t1_rd_drop", rd4, 0); chk("t1_valid_n1", v4, 0); chk("t1_busy_inflight", b4, 1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      chk("t1_valid", v4, 1); chk("t1_data", d4, e1[j]); chk("t1_last", l4, (j == 3));
    end
    @(negedge clk); #1;
    chk("t1_valid_end", v4, 0); chk("t1_busy_end", b4, 0); chk("t1_rd_count", rd_cnt4 - rd0, 1);

    // Three words with ready pattern 1,0,0,1
    clear_got(); rd0 = rd_cnt4; cnt_max = 0; stall_prev = 1'b0; pd = '0;
    pat = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) w[j*32 +: 32] = 32'((i + 1) * 256 + j);
      push4(w);
    end
    for (int k = 0; k < 100 && got_d.size() < 12; k++) begin
      rdy4 = pat[k % 4];
      #1;
      if (stall_prev) chk("t2_stall_hold", d4, pd);
      stall_prev = v4 & ~rdy4; pd = d4;
      @(negedge clk);
    end
    chk("t2_slices", got_d.size(), 12);
    for (int s = 0; s < 12 && s < got_d.size(); s++) begin
      chk("t2_data", got_d[s], 32'((s / 4 + 1) * 256 + s % 4));
      chk("t2_last", got_l[s], (s % 4 == 3));
    end
    chk("t2_rd_count", rd_cnt4 - rd0, 3);
    chk("t2_cnt_le2", (cnt_max <= 2), 1);
    rdy4 = 1'b1;

    // R=1, eight words back to back
    @(negedge clk);
    got1.delete(); rdy1 = 1'b1;
    for (int i = 0; i < 8; i++) push1(32'hC0DE0000 + 32'(i));
    for (int c = 0; c < 14; c++) begin
      #1 rdh[c] = rd1; vh[c] = v1;
      @(negedge clk);
    end
    chk("t3_rd_pattern", rdh, 14'h00FF);
    chk("t3_valid_pattern", vh, 14'h03FC);
    chk("t3_count", got1.size(), 8);
    for (int i = 0; i < 8 && i < got1.size(); i++) chk("t3_data", got1[i], 32'hC0DE0000 + 32'(i));

    // Empty FIFO idle, then a single word
    seen = 1'b0; rd0 = rd_cnt4; clear_got();
    for (int c = 0; c < 20; c++) begin
      #1 seen = seen | rd4 | v4;
      @(negedge clk);
    end
    chk("t4_idle", seen, 0);
    push4(128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C);
    wait_got(4);
    chk("t4_rd_once", rd_cnt4 - rd0, 1);
    chk("t4_slices", got_d.size(), 4);

    // srst mid-word with a second word in flight
    @(negedge clk);
    clear_got();
    push4(128'h13131313_12121212_11111111_10101010);
    @(negedge clk); @(negedge clk); @(negedge clk);
    push4(128'h23232323_22222222_21212121_20202020);
    #1 chk("t5_second_rd", rd4, 1);
    @(negedge clk);
    srst = 1'b1; rdy4 = 1'b0;
    #1 chk("t5_inflight", dut4.inflight_q, 1); chk("t5_rd_in_srst", rd4, 0);
    @(negedge clk);
    srst = 1'b0;
    #1 chk("t5_valid", v4, 0); chk("t5_idx", dut4.idx_q, 0);
    chk("t5_cnt", dut4.cnt_q, 0); chk("t5_busy", b4, 0);
    clear_got(); rdy4 = 1'b1;
    wc = 128'h33333333_32323232_31313131_30303030;
    push4(wc);
    wait_got(4);
    chk("t5_slices", got_d.size(), 4);
    for (int j = 0; j < 4 && j < got_d.size(); j++) chk("t5_data", got_d[j], wc[j*32 +: 32]);
    @(negedge clk); @(negedge clk);

    // Asynchronous reset mid-stream
    push4(128'h43434343_42424242_41414141_40404040);
    push4(128'h53535353_52525252_51515151_50505050);
    push4(128'h63636363_62626262_61616161_60606060);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #3 arst = 1'b1;
    #1;
    chk("t6_valid", v4, 0); chk("t6_data", d4, 0); chk("t6_last", l4, 0);
    chk("t6_busy", b4, 0);  chk("t6_rd", rd4, 0);
    @(negedge clk);
    q4.delete(); f4_mty = 1'b1; arst = 1'b0;
    @(negedge clk);
    clear_got();
    wc = 128'h77777777_76767676_75757575_74747474;
    push4(wc);
    wait_got(4);
    chk("t6_slices", got_d.size(), 4);
    for (int j = 0; j < 4 && j < got_d.size(); j++) begin
      chk("t6_data_after", got_d[j], wc[j*32 +: 32]);
      chk("t6_last_after", got_l[j], (j == 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
